// File: rtl/bce_pkg.sv
// Shared constants, FSM state encoding and sign-magnitude weight conversion
// for the bit-column weight issuer.
package bce_pkg;
   localparam int N_LANES = 8;
   localparam int ACT_W   = 8;
   localparam int WGT_W   = 8;
   localparam int MAG_W   = 7;
   localparam int SH_W    = 3;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_SIGN = 2'd1,
      S_COL  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   typedef struct packed {
      logic             sign;
      logic [MAG_W-1:0] mag;
   } sm_t;

   // -128 has no positive 8-bit counterpart, so it clamps to the largest magnitude.
   function automatic sm_t to_sign_mag(input logic [WGT_W-1:0] w);
      sm_t              r;
      logic [WGT_W-1:0] neg;
      neg    = 8'd0 - w;
      r.sign = w[WGT_W-1];
      if (!w[WGT_W-1])
         r.mag = w[MAG_W-1:0];
      else if (w == 8'h80)
         r.mag = '1;
      else
         r.mag = neg[MAG_W-1:0];
      return r;
   endfunction
endpackage

// File: rtl/bce_column_issuer_col_mask_pe.sv
// Finds the next nonzero magnitude column at or above (incl_i) / strictly
// above (!incl_i) index k_i, and flags whether it is the last one.
module col_mask_pe
   import bce_pkg::*;
#(
   parameter int MAG_W = bce_pkg::MAG_W
) (
   input  logic [MAG_W-1:0] mask_i,
   input  logic [SH_W-1:0]  k_i,
   input  logic             incl_i,
   output logic [SH_W-1:0]  nxt_k_o,
   output logic             found_o,
   output logic             last_o
);
   always_comb begin
      nxt_k_o = '0;
      found_o = 1'b0;
      last_o  = 1'b1;
      for (int j = 0; j < MAG_W; j++) begin
         if (!found_o && mask_i[j] && ((j > int'(k_i)) || (incl_i && (j == int'(k_i))))) begin
            found_o = 1'b1;
            nxt_k_o = SH_W'(j);
         end
      end
      for (int j = 0; j < MAG_W; j++) begin
         if (found_o && mask_i[j] && (j > int'(nxt_k_o)))
            last_o = 1'b0;
      end
   end
endmodule

// File: rtl/bce_column_issuer.sv
// Serialises a group of 8 signed weights into a sign cycle, its nonzero
// magnitude bit columns (zero columns skipped) and an end-of-group marker.
module bce_column_issuer
   import bce_pkg::*;
#(
   parameter int N_LANES = bce_pkg::N_LANES,
   parameter int MAG_W   = bce_pkg::MAG_W
) (
   input  logic                     clk,
   input  logic                     rstn,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [N_LANES*WGT_W-1:0] in_weights,
   input  logic [N_LANES*ACT_W-1:0] in_acts,
   output logic [N_LANES*ACT_W-1:0] activations,
   output logic [N_LANES-1:0]       weight_column,
   output logic                     weight_sign_en,
   output logic [SH_W-1:0]          shift_offset,
   output logic                     done,
   output logic                     busy,
   output state_t                   dbg_state
);
   state_t                            state_q;
   logic [N_LANES*ACT_W-1:0]          act_q, p_act_q, src_act;
   logic [N_LANES-1:0]                sign_q, p_sign_q, in_sign, src_sign;
   logic [MAG_W-1:0][N_LANES-1:0]     cols_q, p_cols_q, in_cols, src_cols;
   logic [MAG_W-1:0]                  mask_q, p_mask_q, in_mask, src_mask;
   logic [SH_W-1:0]                   k_q;
   logic                              last_q, pv_q;
   logic                              accept, start_pend, start_in, load_pend, col_adv;
   logic [SH_W-1:0]                   pe_nxt;
   logic                              pe_found, pe_last;

   always_comb begin
      sm_t sm;
      sm      = '0;
      in_sign = '0;
      in_cols = '0;
      in_mask = '0;
      for (int i = 0; i < N_LANES; i++) begin
         sm         = to_sign_mag(in_weights[WGT_W*i +: WGT_W]);
         in_sign[i] = sm.sign;
         for (int k = 0; k < MAG_W; k++)
            in_cols[k][i] = sm.mag[k];
      end
      for (int k = 0; k < MAG_W; k++)
         in_mask[k] = |in_cols[k];
   end

   assign in_ready   = !pv_q;
   assign accept     = in_valid && in_ready;
   assign start_pend = (state_q == S_DONE) && pv_q;
   // With the pending slot empty, a group arriving in DONE starts straight away.
   assign start_in   = accept && ((state_q == S_IDLE) || ((state_q == S_DONE) && !pv_q));
   assign load_pend  = accept && !start_in;

   assign src_act  = start_pend ? p_act_q  : in_acts;
   assign src_sign = start_pend ? p_sign_q : in_sign;
   assign src_cols = start_pend ? p_cols_q : in_cols;
   assign src_mask = start_pend ? p_mask_q : in_mask;

   col_mask_pe #(.MAG_W(MAG_W)) u_pe (
      .mask_i  (mask_q),
      .k_i     ((state_q == S_SIGN) ? '0 : k_q),
      .incl_i  (state_q == S_SIGN),
      .nxt_k_o (pe_nxt),
      .found_o (pe_found),
      .last_o  (pe_last)
   );

   assign col_adv   = (state_q == S_SIGN) ? pe_found : !last_q;
   assign dbg_state = state_q;

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q        <= S_IDLE;
         pv_q           <= 1'b0;
         k_q            <= '0;
         last_q         <= 1'b0;
         act_q          <= '0;
         sign_q         <= '0;
         cols_q         <= '0;
         mask_q         <= '0;
         p_act_q        <= '0;
         p_sign_q       <= '0;
         p_cols_q       <= '0;
         p_mask_q       <= '0;
         activations    <= '0;
         weight_column  <= '0;
         weight_sign_en <= 1'b0;
         shift_offset   <= '0;
         done           <= 1'b0;
         busy           <= 1'b0;
      end else begin
         weight_sign_en <= 1'b0;
         done           <= 1'b0;
         if (load_pend) begin
            pv_q     <= 1'b1;
            p_act_q  <= in_acts;
            p_sign_q <= in_sign;
            p_cols_q <= in_cols;
            p_mask_q <= in_mask;
         end else if (start_pend) begin
            pv_q <= 1'b0;
         end
         case (state_q)
            S_IDLE, S_DONE: begin
               if (start_pend || start_in) begin
                  state_q        <= S_SIGN;
                  act_q          <= src_act;
                  sign_q         <= src_sign;
                  cols_q         <= src_cols;
                  mask_q         <= src_mask;
                  activations    <= src_act;
                  weight_column  <= src_sign;
                  weight_sign_en <= 1'b1;
                  shift_offset   <= '0;
                  busy           <= 1'b1;
               end else begin
                  state_q       <= S_IDLE;
                  activations   <= '0;
                  weight_column <= '0;
                  shift_offset  <= '0;
                  busy          <= load_pend;
               end
            end
            S_SIGN, S_COL: begin
               busy <= 1'b1;
               if (col_adv) begin
                  state_q       <= S_COL;
                  k_q           <= pe_nxt;
                  last_q        <= pe_last;
                  weight_column <= cols_q[pe_nxt];
                  shift_offset  <= pe_nxt;
               end else begin
                  state_q       <= S_DONE;
                  weight_column <= '0;
                  shift_offset  <= '0;
                  done          <= 1'b1;
               end
            end
         endcase
      end
   end
endmodule

// File: tb/tb_bce_column_issuer.sv
// Directed bench for bce_column_issuer: expected output cycles are queued at
// accept time and a monitor pops/compares every cycle the DUT presents output.
module tb_bce_column_issuer;
   import bce_pkg::*;

   localparam int RW = 77;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [63:0] in_weights = '0;
   logic [63:0] in_acts = '0;
   logic [63:0] activations;
   logic [7:0]  weight_column;
   logic        weight_sign_en;
   logic [2:0]  shift_offset;
   logic        done;
   logic        busy;
   state_t      dbg_state;

   int vec_cnt = 0;
   int err_cnt = 0;
   logic [RW-1:0] exp_q[$];
   logic [RW-1:0] stage_q[$];

   bce_column_issuer dut (
      .clk            (clk),
      .rstn           (rstn),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .in_weights     (in_weights),
      .in_acts        (in_acts),
      .activations    (activations),
      .weight_column  (weight_column),
      .weight_sign_en (weight_sign_en),
      .shift_offset   (shift_offset),
      .done           (done),
      .busy           (busy),
      .dbg_state      (dbg_state)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- helpers / driver tasks ----------------
   function automatic logic [63:0] rep(input logic [7:0] b);
      return {8{b}};
   endfunction

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
      vec_cnt++;
      if (got !== want) begin
         err_cnt++;
         $display("FAIL %s: got %h want %h", name, got, want);
      end
   endtask

   task automatic stage(input logic [63:0] a, input logic [7:0] wc, input logic se,
                        input logic [2:0] sh, input logic d);
      stage_q.push_back({a, wc, se, sh, d});
   endtask

   // Offers one group; staged expectations move to the scoreboard on accept.
   task automatic send(input logic [63:0] w, input logic [63:0] a, input bit hold,
                       output int stalls);
      stalls = 0;
      @(negedge clk);
      in_valid   = 1'b1;
      in_weights = w;
      in_acts    = a;
      while (!in_ready && stalls < 40) begin
         stalls++;
         @(negedge clk);
      end
      if (!in_ready) begin
         vec_cnt++;
         err_cnt++;
         $display("FAIL accept_timeout: in_ready stuck low after %0d cycles", stalls);
         stage_q.delete();
         in_valid = 1'b0;
      end else begin
         while (stage_q.size() > 0) exp_q.push_back(stage_q.pop_front());
         @(posedge clk);
         #1;
         if (!hold) in_valid = 1'b0;
      end
   endtask

   task automatic wait_drain(input string name);
      int n;
      n = 0;
      while (exp_q.size() > 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      vec_cnt++;
      if (exp_q.size() != 0) begin
         err_cnt++;
         $display("FAIL %s_drain: %0d expected cycles never appeared, required 0", name, exp_q.size());
         exp_q.delete();
      end
      repeat (2) @(negedge clk);
      check({name, "_idle_busy"}, 64'(busy), 64'd0);
      check({name, "_idle_ready"}, 64'(in_ready), 64'd1);
   endtask

   // ---------------- scoreboard monitor ----------------
   initial begin
      logic [RW-1:0] got;
      logic [RW-1:0] want;
      logic          present;
      forever begin
         @(posedge clk);
         #1;
         got     = {activations, weight_column, weight_sign_en, shift_offset, done};
         present = weight_sign_en || done || (|weight_column) || (|shift_offset) || (|activations);
         if (present) begin
            vec_cnt++;
            if (exp_q.size() == 0) begin
               err_cnt++;
               $display("FAIL unexpected_output: got %h required no output", got);
            end else begin
               want = exp_q.pop_front();
               if (got !== want) begin
                  err_cnt++;
                  $display("FAIL output_cycle: got act=%h col=%h se=%b sh=%0d done=%b want act=%h col=%h se=%b sh=%0d done=%b",
                           got[76:13], got[12:5], got[4], got[3:1], got[0],
                           want[76:13], want[12:5], want[4], want[3:1], want[0]);
               end
            end
         end else if (exp_q.size() > 0) begin
            vec_cnt++;
            err_cnt++;
            $display("FAIL gap: idle output cycle while %0d cycles still expected", exp_q.size());
         end
      end
   end

   // ---------------- directed stimulus ----------------
   initial begin
      int st1, st2, st3;
      logic [63:0] a;

      rstn = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_ready", 64'(in_ready), 64'd1);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_state", 64'(dbg_state), 64'(S_IDLE));
      check("rst_outs", {activations[55:0], weight_column}, 64'd0);
      rstn = 1'b1;
      @(negedge clk);

      // all weights +3: columns k0 and k1 full
      a = rep(8'h01);
      stage(a, 8'h00, 1'b1, 3'd0, 1'b0);
      stage(a, 8'hFF, 1'b0, 3'd0, 1'b0);
      stage(a, 8'hFF, 1'b0, 3'd1, 1'b0);
      stage(a, 8'h00, 1'b0, 3'd0, 1'b1);
      send(rep(8'h03), a, 1'b0, st1);
      @(negedge clk);
      check("g34_busy", 64'(busy), 64'd1);
      check("g34_ready", 64'(in_ready), 64'd1);
      wait_drain("g34");

      // all weights zero: sign then done
      a = 64'h0807060504030201;
      stage(a, 8'h00, 1'b1, 3'd0, 1'b0);
      stage(a, 8'h00, 1'b0, 3'd0, 1'b1);
      send(64'h0, a, 1'b0, st1);
      wait_drain("g35");

      // lane0 = -128 saturates to magnitude 127
      a = 64'h1122334455667788;
      stage(a, 8'h01, 1'b1, 3'd0, 1'b0);
      for (int k = 0; k < 7; k++) stage(a, 8'h01, 1'b0, 3'(k), 1'b0);
      stage(a, 8'h00, 1'b0, 3'd0, 1'b1);
      send(64'h0000000000000080, a, 1'b0, st1);
      wait_drain("g36");

      // magnitude 64 everywhere, lane1 negative: only column 6
      a = 64'hA0A1A2A3A4A5A6A7;
      stage(a, 8'h02, 1'b1, 3'd0, 1'b0);
      stage(a, 8'hFF, 1'b0, 3'd6, 1'b0);
      stage(a, 8'h00, 1'b0, 3'd0, 1'b1);
      send(64'h404040404040C040, a, 1'b0, st1);
      wait_drain("g_k6");

      // lane3 = -5, others +5
      a = 64'hFFEEDDCCBBAA9988;
      stage(a, 8'h08, 1'b1, 3'd0, 1'b0);
      stage(a, 8'hFF, 1'b0, 3'd0, 1'b0);
      stage(a, 8'hFF, 1'b0, 3'd2, 1'b0);
      stage(a, 8'h00, 1'b0, 3'd0, 1'b1);
      send(64'h05050505FB050505, a, 1'b0, st1);
      wait_drain("g39");

      // three back-to-back groups with in_valid held
      a = rep(8'h11);
      stage(a, 8'h00, 1'b1, 3'd0, 1'b0);
      stage(a, 8'hFF, 1'b0, 3'd0, 1'b0);
      stage(a, 8'hFF, 1'b0, 3'd1, 1'b0);
      stage(a, 8'h00, 1'b0, 3'd0, 1'b1);
      send(rep(8'h03), a, 1'b1, st1);
      a = rep(8'h22);
      stage(a, 8'h00, 1'b1, 3'd0, 1'b0);
      stage(a, 8'h00, 1'b0, 3'd0, 1'b1);
      send(64'h0, a, 1'b1, st2);
      a = rep(8'h33);
      stage(a, 8'h08, 1'b1, 3'd0, 1'b0);
      stage(a, 8'hFF, 1'b0, 3'd0, 1'b0);
      stage(a, 8'hFF, 1'b0, 3'd2, 1'b0);
      stage(a, 8'h00, 1'b0, 3'd0, 1'b1);
      send(64'h05050505FB050505, a, 1'b0, st3);
      check("g37_g2_stall", 64'(st2), 64'd0);
      check("g37_g3_stall", 64'(st3), 64'd3);
      wait_drain("g37");

      // reset asserted for one edge while a column is on the outputs
      a = rep(8'h44);
      stage(a, 8'h00, 1'b1, 3'd0, 1'b0);
      stage(a, 8'hFF, 1'b0, 3'd0, 1'b0);
      send(rep(8'h7F), a, 1'b0, st1);
      @(negedge clk);
      check("g38_busy_pre", 64'(busy), 64'd1);
      @(negedge clk);
      rstn = 1'b0;
      exp_q.delete();
      @(negedge clk);
      rstn = 1'b1;
      check("g38_ready", 64'(in_ready), 64'd1);
      check("g38_busy", 64'(busy), 64'd0);
      check("g38_done", 64'(done), 64'd0);
      check("g38_outs", {activations[55:0], weight_column}, 64'd0);
      check("g38_state", 64'(dbg_state), 64'(S_IDLE));

      // recovery after reset
      a = rep(8'h55);
      stage(a, 8'h00, 1'b1, 3'd0, 1'b0);
      stage(a, 8'hFF, 1'b0, 3'd0, 1'b0);
      stage(a, 8'h00, 1'b0, 3'd0, 1'b1);
      send(rep(8'h01), a, 1'b0, st1);
      wait_drain("g_post_rst");

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end
endmodule
